// File: rtl/execute_cr_arb.sv
// Round-robin arbiter of ALU (A) and mul/div (B) CR field results onto the single CR write port.
// Latency: an entry accepted at edge N is presented next cycle and written at edge N+1 if granted.
// Backpressure: x_ready drops when that FIFO is full or flush is high; cr_wr_hold stalls all pops.
module execute_cr_arb #(
  parameter int DEPTH  = 2,
  parameter int NFIELD = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [$clog2(NFIELD)-1:0] a_field,
  input  logic [3:0]                a_crf,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [$clog2(NFIELD)-1:0] b_field,
  input  logic [3:0]                b_crf,
  input  logic                      cr_wr_hold,
  input  logic                      flush,
  output logic                      cr_wr_en,
  output logic [$clog2(NFIELD)-1:0] cr_wr_field,
  output logic [3:0]                cr_wr_data,
  output logic [NFIELD-1:0]         cr_busy
);

  localparam int FW = $clog2(NFIELD);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(2 * DEPTH) + 1;

  typedef struct packed {
    logic [FW-1:0] fld;
    logic [3:0]    crf;
  } ent_t;

  // Index 0 is requester A, index 1 is requester B.
  ent_t          mem_q  [2][DEPTH];
  logic [AW-1:0] wp_q   [2];
  logic [AW-1:0] rp_q   [2];
  logic [OW-1:0] occ_q  [2];
  logic          last_b_q;
  logic [CW-1:0] fcnt_q [NFIELD];
  logic [CW-1:0] fcnt_d [NFIELD];

  ent_t       in_ent [2];
  ent_t       head   [2];
  ent_t       wr_ent;
  logic [1:0] ready;
  logic [1:0] nonempty;
  logic [1:0] push;
  logic [1:0] pop;
  logic       wr_en;
  logic       grant_b;

  // FIFO status from registered occupancy only; ready is held low while in reset.
  always_comb begin
    in_ent[0] = '{fld: a_field, crf: a_crf};
    in_ent[1] = '{fld: b_field, crf: b_crf};
    for (int r = 0; r < 2; r++) begin
      nonempty[r] = (occ_q[r] != '0);
      ready[r]    = reset_n && (occ_q[r] != OW'(DEPTH)) && !flush;
      head[r]     = mem_q[r][rp_q[r]];
    end
    push = {b_valid && ready[1], a_valid && ready[0]};
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];

  // Round-robin grant: a lone non-empty FIFO wins, otherwise the one not granted last.
  always_comb begin
    wr_en   = (|nonempty) && !cr_wr_hold && !flush;
    grant_b = nonempty[1] && (!nonempty[0] || !last_b_q);
    wr_ent  = grant_b ? head[1] : head[0];
    pop     = 2'b00;
    if (wr_en) begin
      pop = grant_b ? 2'b10 : 2'b01;
    end
  end

  assign cr_wr_en    = wr_en;
  assign cr_wr_field = wr_en ? wr_ent.fld : '0;
  assign cr_wr_data  = wr_en ? wr_ent.crf : '0;

  // FIFO pointers and occupancy; flush empties both queues at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 2; r++) begin
        wp_q[r]  <= '0;
        rp_q[r]  <= '0;
        occ_q[r] <= '0;
      end
    end else if (flush) begin
      for (int r = 0; r < 2; r++) begin
        wp_q[r]  <= '0;
        rp_q[r]  <= '0;
        occ_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) wp_q[r] <= wp_q[r] + AW'(1);
        if (pop[r])  rp_q[r] <= rp_q[r] + AW'(1);
        occ_q[r] <= occ_q[r] + OW'(push[r]) - OW'(pop[r]);
      end
    end
  end

  // FIFO storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) mem_q[r][wp_q[r]] <= in_ent[r];
    end
  end

  // Last grant moves only on a real pop; reset to B so A wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_b_q <= 1'b1;
    end else if (|pop) begin
      last_b_q <= pop[1];
    end
  end

  // Per-field pending count: pushes add, the popped entry subtracts, flush clears.
  always_comb begin
    for (int f = 0; f < NFIELD; f++) begin
      fcnt_d[f] = fcnt_q[f];
      if (push[0] && (in_ent[0].fld == FW'(f))) fcnt_d[f] = fcnt_d[f] + CW'(1);
      if (push[1] && (in_ent[1].fld == FW'(f))) fcnt_d[f] = fcnt_d[f] + CW'(1);
      if ((|pop) && (wr_ent.fld == FW'(f)))     fcnt_d[f] = fcnt_d[f] - CW'(1);
      if (flush) fcnt_d[f] = '0;
      cr_busy[f] = (fcnt_q[f] != '0);
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int f = 0; f < NFIELD; f++) fcnt_q[f] <= '0;
    end else begin
      for (int f = 0; f < NFIELD; f++) fcnt_q[f] <= fcnt_d[f];
    end
  end

endmodule

// File: tb/tb_execute_cr_arb.sv
// Bench for execute_cr_arb: directed scenarios plus randomized traffic against a queue-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// The model holds one queue per requester and derives busy bits from queue contents.
module tb_execute_cr_arb;

  localparam int DEPTH  = 2;
  localparam int NFIELD = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, b_ready;
  logic [2:0] a_field = '0, b_field = '0;
  logic [3:0] a_crf = '0, b_crf = '0;
  logic       cr_wr_hold = 1'b0, flush = 1'b0;
  logic       cr_wr_en;
  logic [2:0] cr_wr_field;
  logic [3:0] cr_wr_data;
  logic [7:0] cr_busy;

  int checks = 0;
  int failures = 0;

  execute_cr_arb #(.DEPTH(DEPTH), .NFIELD(NFIELD)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_field(a_field), .a_crf(a_crf),
    .b_valid(b_valid), .b_ready(b_ready), .b_field(b_field), .b_crf(b_crf),
    .cr_wr_hold(cr_wr_hold), .flush(flush),
    .cr_wr_en(cr_wr_en), .cr_wr_field(cr_wr_field), .cr_wr_data(cr_wr_data),
    .cr_busy(cr_busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] f;
    logic [3:0] d;
  } ent_t;

  typedef struct packed {
    logic       ra;
    logic       rb;
    logic       en;
    logic       sel_a;
    logic [2:0] fld;
    logic [3:0] dat;
    logic [7:0] busy;
  } exp_t;

  ent_t qa[$];
  ent_t qb[$];
  bit   m_last_b = 1'b1;
  exp_t m_e;

  function automatic exp_t model_exp();
    exp_t e;
    e = '0;
    if (reset_n) begin
      e.ra    = (qa.size() != DEPTH) && !flush;
      e.rb    = (qb.size() != DEPTH) && !flush;
      e.en    = (qa.size() != 0 || qb.size() != 0) && !cr_wr_hold && !flush;
      e.sel_a = (qa.size() != 0) && (qb.size() == 0 || m_last_b);
      if (e.en) begin
        if (e.sel_a) begin e.fld = qa[0].f; e.dat = qa[0].d; end
        else         begin e.fld = qb[0].f; e.dat = qb[0].d; end
      end
      foreach (qa[i]) e.busy[qa[i].f] = 1'b1;
      foreach (qb[i]) e.busy[qb[i].f] = 1'b1;
    end
    return e;
  endfunction

  function automatic int model_count(input int f);
    int n;
    n = 0;
    foreach (qa[i]) if (int'(qa[i].f) == f) n++;
    foreach (qb[i]) if (int'(qb[i].f) == f) n++;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      m_last_b = 1'b1;
    end else begin
      m_e = model_exp();
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (m_e.en) begin
          if (m_e.sel_a) begin void'(qa.pop_front()); m_last_b = 1'b0; end
          else           begin void'(qb.pop_front()); m_last_b = 1'b1; end
        end
        if (a_valid && m_e.ra) qa.push_back('{f: a_field, d: a_crf});
        if (b_valid && m_e.rb) qb.push_back('{f: b_field, d: b_crf});
      end
    end
  end

  // Scoreboard counters: match the queued entry count, never exceed 2*DEPTH, never wrap below 0.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int f = 0; f < NFIELD; f++) begin
        checks++;
        if (int'(dut.fcnt_q[f]) != model_count(f)) begin
          failures++;
          $display("FAIL fcnt_track[%0d] got=%0d want=%0d", f, dut.fcnt_q[f], model_count(f));
        end
        checks++;
        if (int'(dut.fcnt_q[f]) > 2 * DEPTH) begin
          failures++;
          $display("FAIL fcnt_bound[%0d] got=%0d limit=%0d", f, dut.fcnt_q[f], 2 * DEPTH);
        end
      end
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_valid = 1'b0; b_valid = 1'b0;
    a_field = '0; b_field = '0; a_crf = '0; b_crf = '0;
    cr_wr_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    next_edge();
    reset_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) next_edge();
    checks++;
    if ({a_ready, b_ready, cr_wr_en, cr_wr_field, cr_wr_data, cr_busy} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {a_ready, b_ready, cr_wr_en, cr_wr_field, cr_wr_data, cr_busy});
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_ready, b_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready_rise got=%b want=11", {a_ready, b_ready});
    end
    checks++;
    if ({cr_wr_en, cr_busy} !== 9'd0) begin
      failures++;
      $display("FAIL reset_idle got=%b want=0", {cr_wr_en, cr_busy});
    end
  endtask

  task automatic test_single_write();
    next_edge();
    a_valid = 1'b1; a_field = 3'd2; a_crf = 4'b1000;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL single_accept got=%b want=1", a_ready); end
    next_edge();
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({cr_wr_en, cr_wr_field, cr_wr_data} !== {1'b1, 3'd2, 4'b1000}) begin
      failures++;
      $display("FAIL single_write got=%b_%0d_%b want=1_2_1000", cr_wr_en, cr_wr_field, cr_wr_data);
    end
    checks++;
    if (cr_busy !== 8'h04) begin failures++; $display("FAIL single_busy got=%h want=04", cr_busy); end
    next_edge();
    @(negedge clk);
    checks++;
    if ({cr_wr_en, cr_wr_field, cr_wr_data, cr_busy} !== 16'd0) begin
      failures++;
      $display("FAIL single_after got=%b_%0d_%b busy=%h want=0", cr_wr_en, cr_wr_field, cr_wr_data, cr_busy);
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] ra [3];
    logic [6:0] rb [3];
    logic [6:0] seq [6];
    int ai, bi, k;
    logic acc_a, acc_b;
    ra = '{{3'd0, 4'hA}, {3'd1, 4'h3}, {3'd3, 4'h5}};
    rb = '{{3'd4, 4'h9}, {3'd5, 4'h6}, {3'd6, 4'hC}};
    seq = '{ra[0], rb[0], ra[1], rb[1], ra[2], rb[2]};
    do_reset();
    ai = 0; bi = 0; k = 0;
    a_valid = 1'b1; {a_field, a_crf} = ra[0];
    b_valid = 1'b1; {b_field, b_crf} = rb[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      if (cr_wr_en) begin
        checks++;
        if (k >= 6) begin
          failures++;
          $display("FAIL rr_extra got=%0d_%h want=no_write", cr_wr_field, cr_wr_data);
        end else if ({cr_wr_field, cr_wr_data} !== seq[k]) begin
          failures++;
          $display("FAIL rr_order[%0d] got=%0d_%h want=%0d_%h", k, cr_wr_field, cr_wr_data, seq[k][6:4], seq[k][3:0]);
        end
        k++;
      end else if (k > 0 && k < 6) begin
        checks++;
        failures++;
        $display("FAIL rr_idle[%0d] got=en0 want=en1", k);
      end
      next_edge();
      if (acc_a) begin
        ai++;
        if (ai < 3) {a_field, a_crf} = ra[ai]; else a_valid = 1'b0;
      end
      if (acc_b) begin
        bi++;
        if (bi < 3) {b_field, b_crf} = rb[bi]; else b_valid = 1'b0;
      end
    end
    checks++;
    if (k != 6) begin failures++; $display("FAIL rr_count got=%0d want=6", k); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cr_wr_hold = 1'b1;
    a_valid = 1'b1; a_field = 3'd1; a_crf = 4'h1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b want=1", a_ready); end
    next_edge();
    a_field = 3'd2; a_crf = 4'h2;
    @(negedge clk);
    checks++;
    if ({a_ready, cr_wr_en} !== 2'b10) begin failures++; $display("FAIL bp_ready1 got=%b want=10", {a_ready, cr_wr_en}); end
    next_edge();
    a_field = 3'd3; a_crf = 4'h3;
    @(negedge clk);
    checks++;
    if ({a_ready, cr_wr_en, cr_busy} !== {2'b00, 8'h06}) begin
      failures++;
      $display("FAIL bp_full got=%b busy=%h want=00 busy=06", {a_ready, cr_wr_en}, cr_busy);
    end
    next_edge();
    cr_wr_hold = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_ready, cr_wr_en, cr_wr_field, cr_wr_data} !== {2'b01, 3'd1, 4'h1}) begin
      failures++;
      $display("FAIL bp_release1 got=%b_%b_%0d_%h want=0_1_1_1", a_ready, cr_wr_en, cr_wr_field, cr_wr_data);
    end
    next_edge();
    @(negedge clk);
    checks++;
    if ({a_ready, cr_wr_en, cr_wr_field, cr_wr_data} !== {2'b11, 3'd2, 4'h2}) begin
      failures++;
      $display("FAIL bp_release2 got=%b_%b_%0d_%h want=1_1_2_2", a_ready, cr_wr_en, cr_wr_field, cr_wr_data);
    end
    next_edge();
    a_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({cr_wr_en, cr_wr_field, cr_wr_data, cr_busy} !== {1'b1, 3'd3, 4'h3, 8'h08}) begin
      failures++;
      $display("FAIL bp_third got=%b_%0d_%h busy=%h want=1_3_3 busy=08", cr_wr_en, cr_wr_field, cr_wr_data, cr_busy);
    end
    next_edge();
    @(negedge clk);
    checks++;
    if ({cr_wr_en, cr_busy} !== 9'd0) begin failures++; $display("FAIL bp_drain got=%b want=0", {cr_wr_en, cr_busy}); end
  endtask

  task automatic test_collision();
    do_reset();
    a_valid = 1'b1; a_field = 3'd7; a_crf = 4'h8;
    b_valid = 1'b1; b_field = 3'd7; b_crf = 4'h4;
    next_edge();
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.fcnt_q[7] !== 3'd2) begin failures++; $display("FAIL coll_count got=%0d want=2", dut.fcnt_q[7]); end
    checks++;
    if ({cr_busy, cr_wr_en, cr_wr_field, cr_wr_data} !== {8'h80, 1'b1, 3'd7, 4'h8}) begin
      failures++;
      $display("FAIL coll_first got=busy%h_%b_%0d_%h want=busy80_1_7_8", cr_busy, cr_wr_en, cr_wr_field, cr_wr_data);
    end
    next_edge();
    @(negedge clk);
    checks++;
    if ({cr_busy, cr_wr_en, cr_wr_field, cr_wr_data} !== {8'h80, 1'b1, 3'd7, 4'h4}) begin
      failures++;
      $display("FAIL coll_second got=busy%h_%b_%0d_%h want=busy80_1_7_4", cr_busy, cr_wr_en, cr_wr_field, cr_wr_data);
    end
    next_edge();
    @(negedge clk);
    checks++;
    if ({cr_busy, cr_wr_en} !== 9'd0) begin failures++; $display("FAIL coll_clear got=%b want=0", {cr_busy, cr_wr_en}); end
  endtask

  task automatic test_flush();
    do_reset();
    cr_wr_hold = 1'b1;
    a_valid = 1'b1; a_field = 3'd1; a_crf = 4'h1;
    b_valid = 1'b1; b_field = 3'd2; b_crf = 4'h2;
    next_edge();
    a_field = 3'd3; a_crf = 4'h3;
    b_field = 3'd4; b_crf = 4'h4;
    next_edge();
    flush = 1'b1;
    b_valid = 1'b0;
    a_field = 3'd5; a_crf = 4'h5;
    @(negedge clk);
    checks++;
    if ({cr_wr_en, a_ready, b_ready} !== 3'b000) begin
      failures++;
      $display("FAIL flush_cycle got=%b want=000", {cr_wr_en, a_ready, b_ready});
    end
    checks++;
    if (cr_busy !== 8'h1E) begin failures++; $display("FAIL flush_busy_before got=%h want=1e", cr_busy); end
    next_edge();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({cr_busy, cr_wr_en, a_ready} !== {8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flush_after got=busy%h_%b_%b want=busy00_0_1", cr_busy, cr_wr_en, a_ready);
    end
    next_edge();
    @(negedge clk);
    checks++;
    if (cr_wr_en !== 1'b0) begin failures++; $display("FAIL flush_no_accept got=%b want=0", cr_wr_en); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cr_wr_hold = 1'b1;
    a_valid = 1'b1; a_field = 3'd6; a_crf = 4'h6;
    b_valid = 1'b1; b_field = 3'd5; b_crf = 4'h5;
    next_edge();
    a_valid = 1'b0; b_valid = 1'b0;
    cr_wr_hold = 1'b0;
    @(negedge clk);
    checks++;
    if ({cr_wr_en, cr_busy} !== {1'b1, 8'h60}) begin
      failures++;
      $display("FAIL ares_pending got=%b busy=%h want=1 busy=60", cr_wr_en, cr_busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready, cr_wr_en, cr_wr_field, cr_wr_data, cr_busy} !== 19'd0) begin
      failures++;
      $display("FAIL ares_immediate got=%b want=0", {a_ready, b_ready, cr_wr_en, cr_wr_field, cr_wr_data, cr_busy});
    end
    next_edge();
    reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({cr_wr_en, cr_busy} !== 9'd0) begin
        failures++;
        $display("FAIL ares_no_write[%0d] got=%b busy=%h want=0", c, cr_wr_en, cr_busy);
      end
      next_edge();
    end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      a_valid    = ($urandom_range(0, 2) != 0);
      b_valid    = ($urandom_range(0, 2) == 0);
      a_field    = 3'($urandom_range(0, 7));
      b_field    = 3'($urandom_range(0, 7));
      a_crf      = 4'($urandom);
      b_crf      = 4'($urandom);
      cr_wr_hold = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      e = model_exp();
      checks++;
      if ({a_ready, b_ready} !== {e.ra, e.rb}) begin
        failures++;
        $display("FAIL rand_ready[%0d] got=%b want=%b", c, {a_ready, b_ready}, {e.ra, e.rb});
      end
      checks++;
      if ({cr_wr_en, cr_wr_field, cr_wr_data, cr_busy} !== {e.en, e.fld, e.dat, e.busy}) begin
        failures++;
        $display("FAIL rand_port[%0d] got=%b_%0d_%h busy=%h want=%b_%0d_%h busy=%h",
                 c, cr_wr_en, cr_wr_field, cr_wr_data, cr_busy, e.en, e.fld, e.dat, e.busy);
      end
      next_edge();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
